mux_arb_pipe_rtl: RTL

//   N-input, p_nbits-wide selection stage with val/rdy handshakes and a
//   one-entry output register. It is the registered successor of the 2:1 mux.
//   Its source is either a fixed index (sel) or round-robin arbitration

---
 rtl/mux_arb_pipe_rtl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mux_arb_pipe_rtl.sv
// mux_arb_pipe_rtl
//   Registered N:1 selection stage with val/rdy handshakes on every input and
//   on the single output. The source channel is either a fixed index (sel,
//   mode=0) or round-robin among valid inputs (mode=1). The winning channel's
//   word is captured into a one-entry output register. Draining and loading
//   can happen in the same cycle, so the stage sustains one word per cycle.
//
// Ports
//   clk       in   clock, all state on posedge
//   rst_n     in   synchronous active-low reset
//   mode      in   0 = fixed select via sel, 1 = round-robin
//   sel       in   source index for mode=0 (values >= p_ninputs never grant)
//   in_val    in   per-channel valid
//   in_rdy    out  per-channel ready (combinational, one-hot or zero)
//   in_data   in   channel i at [i*p_nbits +: p_nbits]
//   out_val   out  output register holds a word
//   out_rdy   in   consumer ready
//   out_data  out  registered word
//   out_src   out  channel index that supplied out_data
module mux_arb_pipe_rtl #(
    parameter int p_nbits   = 1,
    parameter int p_ninputs = 2,
    localparam int c_selbits = $clog2(p_ninputs)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mode,
    input  logic [c_selbits-1:0]           sel,
    input  logic [p_ninputs-1:0]           in_val,
    output logic [p_ninputs-1:0]           in_rdy,
    input  logic [p_ninputs*p_nbits-1:0]   in_data,
    output logic                           out_val,
    input  logic                           out_rdy,
    output logic [p_nbits-1:0]             out_data,
    output logic [c_selbits-1:0]           out_src
);

    logic [p_ninputs-1:0][p_nbits-1:0] in_data_a;
    assign in_data_a = in_data;

    logic                 out_val_q,  out_val_d;
    logic [p_nbits-1:0]   out_data_q, out_data_d;
    logic [c_selbits-1:0] out_src_q,  out_src_d;
    logic [c_selbits-1:0] rr_ptr_q,   rr_ptr_d;

    logic                 grant_valid;
    logic [c_selbits-1:0] grant;
    logic                 can_load;
    logic                 in_xfer;
    int                   idx;

    // Grant selection. Fixed mode compares sel against every legal index so an
    // out-of-range sel simply matches nothing. Round-robin walks the channels
    // starting at rr_ptr, wrapping by subtraction so non-power-of-2 counts work.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        if (!mode) begin
            for (int i = 0; i < p_ninputs; i++) begin
                if (sel == c_selbits'(i) && in_val[i]) begin
                    grant_valid = 1'b1;
                    grant       = c_selbits'(i);
                end
            end
        end else begin
            for (int k = 0; k < p_ninputs; k++) begin
                idx = int'(rr_ptr_q) + k;
                if (idx >= p_ninputs) idx = idx - p_ninputs;
                if (!grant_valid && in_val[idx]) begin
                    grant_valid = 1'b1;
                    grant       = c_selbits'(idx);
                end
            end
        end
    end

    // A held word that is leaving this cycle frees the register for a new one.
    assign can_load = !out_val_q || out_rdy;

    for (genvar g = 0; g < p_ninputs; g++) begin : g_rdy
        assign in_rdy[g] = rst_n & can_load & grant_valid & (grant == c_selbits'(g));
    end

    assign in_xfer = |(in_val & in_rdy);

    always_comb begin
        out_val_d  = out_val_q;
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
        rr_ptr_d   = rr_ptr_q;
        if (in_xfer) begin
            out_val_d  = 1'b1;
            out_data_d = in_data_a[grant];
            out_src_d  = grant;
            rr_ptr_d   = (grant == c_selbits'(p_ninputs - 1)) ? '0 : grant + 1'b1;
        end else if (out_val_q && out_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_val_q  <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= '0;
            rr_ptr_q   <= '0;
        end else begin
            out_val_q  <= out_val_d;
            out_data_q <= out_data_d;
            out_src_q  <= out_src_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_val  = out_val_q;
    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule
